// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width, frame timing and
// sizing helpers used by the TX arbiter and its interface.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_FRAME_CYCLES = 11;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_e;

    function automatic int grant_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus transmitter control/status bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int GW = grant_width(NREQ);

    logic [NREQ-1:0]             req_valid;
    logic [UART_DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]             req_ready;
    logic [UART_DATA_W-1:0]      txbyte;
    logic                        senddata;
    logic                        txdone;
    logic                        busy;
    logic [GW-1:0]               grant_id;
    logic                        timeout_err;

    modport master (
        output req_valid, req_data, txdone,
        input  req_ready, txbyte, senddata, busy, grant_id, timeout_err
    );

    modport slave (
        input  req_valid, req_data, txdone,
        output req_ready, txbyte, senddata, busy, grant_id, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid at or above i_ptr,
// wrapping at N-1 -> 0.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        int k;
        // NOTE: every output gets a default before the search loop so no path leaves a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(i_ptr) + i) % N;
            if (!o_any && i_valid[k]) begin
                o_any      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 byte transmitter between NREQ requesters, with
// post-reset flush, txdone timeout and an inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 32,
    parameter int FLUSH_CYCLES = 12
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int GW    = grant_width(NREQ);
    localparam int CNT_W = $clog2(max3(TIMEOUT, GAP_CYCLES, FLUSH_CYCLES) + 1);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [GW-1:0]    PTR_LAST   = GW'(NREQ - 1);

    arb_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [GW-1:0]          r_ptr;
    logic [UART_DATA_W-1:0] r_txbyte;
    logic                   r_senddata;
    logic [GW-1:0]          r_grant_id;
    logic                   r_timeout_err;

    logic [NREQ-1:0]        w_pick;
    logic [GW-1:0]          w_pick_idx;
    logic                   w_any;

    rr_pick #(
        .N (NREQ),
        .W (GW)
    ) u_rr_pick (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // Grant is offered only in IDLE, so an accept always coincides with the IDLE->LOAD edge.
    assign bus.req_ready   = (r_state == ST_IDLE) ? w_pick : '0;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.txbyte      = r_txbyte;
    assign bus.senddata    = r_senddata;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_FLUSH;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_txbyte      <= '0;
            r_senddata    <= 1'b0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_senddata    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_FLUSH: begin
                    if (FLUSH_CYCLES == 0 || r_cnt == FLUSH_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_any) begin
                        r_txbyte   <= bus.req_data[UART_DATA_W*int'(w_pick_idx) +: UART_DATA_W];
                        r_grant_id <= w_pick_idx;
                        r_ptr      <= (w_pick_idx == PTR_LAST) ? '0 : w_pick_idx + 1'b1;
                        r_senddata <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // txdone on the final timeout cycle still counts as a clean completion.
                    if (bus.txdone || r_cnt == TO_LAST) begin
                        r_timeout_err <= !bus.txdone;
                        r_cnt         <= '0;
                        r_state       <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural 8N1 transmitter, scoreboard of expected
// grants/bytes, table-driven round-robin vectors and timeout/reset sequences.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ  = 4;
    localparam int GAP   = 2;
    localparam int TO    = 32;
    localparam int FLUSH = 12;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   send_cyc[$];

    int   tx_mode = 0;
    logic force_done = 1'b0;
    logic [9:0] tx_sr = '1;
    int   tx_bits = 0;
    logic model_done = 1'b0;
    logic tx_line;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .GAP_CYCLES   (GAP),
        .TIMEOUT      (TO),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: start bit, 8 data LSB first, stop; txdone 11 cycles after senddata.
    always @(posedge clk) begin
        if (bus.senddata === 1'b1) begin
            tx_sr   <= {1'b1, bus.txbyte, 1'b0};
            tx_bits <= UART_FRAME_CYCLES - 1;
        end else if (tx_bits != 0) begin
            tx_sr   <= {1'b1, tx_sr[9:1]};
            tx_bits <= tx_bits - 1;
        end
        model_done <= (tx_bits == 1) && (bus.senddata !== 1'b1);
    end

    assign tx_line    = (tx_bits != 0) ? tx_sr[0] : 1'b1;
    assign bus.txdone = (tx_mode == 0) ? model_done : (tx_mode == 1) ? 1'b0 : force_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.senddata === 1'b1) begin
            send_cyc.push_back(cyc);
            check("send_was_expected", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) begin
                check("txbyte", 32'(bus.txbyte), 32'(sb_q[0].data));
                check("grant_id", 32'(bus.grant_id), 32'(sb_q[0].id));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(bus.busy === 1'b0), 32'(1));
    endtask

    task automatic wait_send(input int budget);
        int n;
        n = 0;
        while (bus.senddata !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("senddata_within_budget", 32'(bus.senddata === 1'b1), 32'(1));
    endtask

    task automatic check_serial(input logic [7:0] b);
        logic [9:0] frame;
        logic [9:0] got;
        frame = {1'b1, b, 1'b0};
        got   = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got[k] = tx_line;
        end
        check("serial_frame", 32'(got), 32'(frame));
    endtask

    // Drives one request from IDLE and returns on the negedge of its senddata cycle.
    task automatic run_vec(input vec_t v, input bit serial);
        exp_t       e;
        logic [7:0] b;
        wait_idle(60);
        b      = v.data[8*int'(v.exp_id) +: 8];
        e.id   = v.exp_id;
        e.data = b;
        sb_q.push_back(e);
        bus.req_valid = v.valid;
        bus.req_data  = v.data;
        #1;
        check("req_ready_onehot", 32'(bus.req_ready), 32'(4'(4'b0001 << v.exp_id)));
        @(negedge clk);
        bus.req_valid = '0;
        wait_send(4);
        if (serial) check_serial(b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        exp_t e;
        int   early;

        tbl[0] = '{4'b0010, 32'h13121110, 2'd1};
        tbl[1] = '{4'b0011, 32'h23222120, 2'd0};
        tbl[2] = '{4'b0011, 32'h33323130, 2'd1};
        tbl[3] = '{4'b0101, 32'h43424140, 2'd2};
        tbl[4] = '{4'b0110, 32'h53525150, 2'd1};
        tbl[5] = '{4'b1000, 32'h63626160, 2'd3};

        // Reset with a request already pending; it must wait out the flush.
        rst           = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h000000A5;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_txbyte", 32'(bus.txbyte), 32'(0));
        check("rst_senddata", 32'(bus.senddata), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(1));
        check("rst_grant_id", 32'(bus.grant_id), 32'(0));
        check("rst_timeout_err", 32'(bus.timeout_err), 32'(0));

        rst   = 1'b0;
        early = 0;
        for (int i = 0; i < FLUSH; i++) begin
            #1;
            if (bus.req_ready != 4'b0000) early++;
            @(negedge clk);
        end
        check("flush_holdoff", 32'(early), 32'(0));
        e.id   = 2'd0;
        e.data = 8'hA5;
        sb_q.push_back(e);
        #1;
        check("first_ready", 32'(bus.req_ready), 32'(4'b0001));
        @(negedge clk);
        bus.req_valid = '0;
        wait_send(4);
        check_serial(8'hA5);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], 1'b0);

        // All requesters continuously valid: strict rotation, back-to-back frame spacing.
        wait_idle(60);
        send_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            e.id   = 2'(i % 4);
            e.data = 8'h10 + 8'(i % 4);
            sb_q.push_back(e);
        end
        bus.req_data  = 32'h13121110;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_send(40);
            @(negedge clk);
            if (i == 4) bus.req_valid = '0;
        end
        check("send_count", 32'(send_cyc.size()), 32'(5));
        for (int i = 1; i < 5 && i < send_cyc.size(); i++)
            check("send_spacing", 32'(send_cyc[i] - send_cyc[i-1]), 32'(1 + UART_FRAME_CYCLES + GAP + 1));

        // Stubbed transmitter: abandon after TO cycles of WAIT_DONE.
        tx_mode = 1;
        v = '{4'b0100, 32'hDDCCBBAA, 2'd2};
        run_vec(v, 1'b0);
        early = 0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            if (bus.timeout_err !== 1'b0) early++;
        end
        check("no_early_timeout", 32'(early), 32'(0));
        @(negedge clk);
        check("timeout_pulse", 32'(bus.timeout_err), 32'(1));
        check("timeout_then_gap", 32'(bus.busy), 32'(1));
        @(negedge clk);
        check("timeout_one_cycle", 32'(bus.timeout_err), 32'(0));
        tx_mode = 0;
        v = '{4'b0001, 32'h0000005A, 2'd0};
        run_vec(v, 1'b0);

        // txdone arriving on the last timeout cycle wins.
        wait_idle(60);
        tx_mode    = 2;
        force_done = 1'b0;
        v = '{4'b0010, 32'h00003C00, 2'd1};
        run_vec(v, 1'b0);
        repeat (TO) @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        check("race_no_timeout", 32'(bus.timeout_err), 32'(0));
        check("race_gap1_busy", 32'(bus.busy), 32'(1));
        @(negedge clk);
        check("race_gap2_busy", 32'(bus.busy), 32'(1));
        @(negedge clk);
        check("race_back_idle", 32'(bus.busy), 32'(0));
        tx_mode = 0;

        // Asynchronous reset in the middle of a frame.
        v = '{4'b0100, 32'h00E70000, 2'd2};
        run_vec(v, 1'b0);
        repeat (5) @(negedge clk);
        bus.req_valid = 4'b0001;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(bus.req_ready), 32'(0));
        check("midrst_txbyte", 32'(bus.txbyte), 32'(0));
        check("midrst_busy", 32'(bus.busy), 32'(1));
        check("midrst_grant_id", 32'(bus.grant_id), 32'(0));
        check("midrst_senddata", 32'(bus.senddata), 32'(0));
        @(negedge clk);
        bus.req_valid = '0;
        rst           = 1'b0;
        v = '{4'b1010, 32'h00004B00, 2'd1};
        run_vec(v, 1'b1);

        wait_idle(60);
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
